// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 32-bit MIPS-subset datapath.
// Define MULTICYCLE_CTRL_PERF_EN to add retired-instruction and cycle counters.
module multicycle_ctrl #(
  parameter int MEM_LAT     = 1,
  parameter bit TRAP_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic [2:0] iord,
  output logic       mem_write,
  output logic       load_a,
  output logic       load_b,
  output logic       load_aluout,
  output logic [2:0] alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [2:0] reg_dst,
  output logic [4:0] mem_to_reg,
  output logic       illegal,
  output logic [3:0] state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] cycle_count
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB       = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_TRAP     = 4'd10
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_ADD, C_SUB, C_AND, C_OR, C_SLT,
    C_ADDI, C_LW, C_SW, C_BEQ, C_BNE, C_J
  } cls_e;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d, dec_cls;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    dec_cls = C_NONE;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20:   dec_cls = C_ADD;
          6'h22:   dec_cls = C_SUB;
          6'h24:   dec_cls = C_AND;
          6'h25:   dec_cls = C_OR;
          6'h2A:   dec_cls = C_SLT;
          default: dec_cls = C_NONE;
        endcase
      end
      6'h08:   dec_cls = C_ADDI;
      6'h23:   dec_cls = C_LW;
      6'h2B:   dec_cls = C_SW;
      6'h04:   dec_cls = C_BEQ;
      6'h05:   dec_cls = C_BNE;
      6'h02:   dec_cls = C_J;
      default: dec_cls = C_NONE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    iord        = 3'd0;
    mem_write   = 1'b0;
    load_a      = 1'b0;
    load_b      = 1'b0;
    load_aluout = 1'b0;
    alu_src_a   = 3'd0;
    alu_src_b   = 3'd0;
    alu_op      = 3'd0;
    pc_src      = 2'd0;
    reg_write   = 1'b0;
    reg_dst     = 3'd0;
    mem_to_reg  = 5'd0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 3'd1;
        alu_op    = 3'd1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        load_a      = 1'b1;
        load_b      = 1'b1;
        alu_src_b   = 3'd3;
        alu_op      = 3'd1;
        load_aluout = 1'b1;
        cls_d       = dec_cls;
        case (dec_cls)
          C_ADD, C_SUB, C_AND, C_OR, C_SLT: state_d = S_EXEC_R;
          C_ADDI:                           state_d = S_EXEC_I;
          C_LW, C_SW:                       state_d = S_MEM_ADDR;
          C_BEQ, C_BNE:                     state_d = S_BRANCH;
          C_J:                              state_d = S_JUMP;
          default:                          state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a   = 3'd1;
        load_aluout = 1'b1;
        case (cls_q)
          C_ADD:   alu_op = 3'd1;
          C_SUB:   alu_op = 3'd2;
          C_AND:   alu_op = 3'd3;
          C_OR:    alu_op = 3'd4;
          C_SLT:   alu_op = 3'd5;
          default: alu_op = 3'd0;
        endcase
        state_d = S_WB;
      end
      S_EXEC_I: begin
        alu_src_a   = 3'd1;
        alu_src_b   = 3'd2;
        alu_op      = 3'd1;
        load_aluout = 1'b1;
        state_d     = S_WB;
      end
      S_MEM_ADDR: begin
        alu_src_a   = 3'd1;
        alu_src_b   = 3'd2;
        alu_op      = 3'd1;
        load_aluout = 1'b1;
        cnt_d       = 4'd0;
        state_d     = (cls_q == C_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord = 3'd1;
        if (cnt_q == LAT_M1) begin
          cnt_d   = 4'd0;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_MEM_WR: begin
        iord      = 3'd1;
        mem_write = 1'b1;
        if (cnt_q == LAT_M1) begin
          cnt_d   = 4'd0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls_q == C_ADDI || cls_q == C_LW) ? 3'd1 : 3'd0;
        mem_to_reg = (cls_q == C_LW) ? 5'd1 : 5'd0;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 3'd1;
        alu_op    = 3'd2;
        pc_src    = 2'd1;
        pc_write  = (cls_q == C_BNE) ? ~zero : zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'd2;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = TRAP_STICKY ? S_TRAP : S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset kills every strobe combinationally so an interrupted write never lands.
    if (reset) begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      iord        = 3'd0;
      mem_write   = 1'b0;
      load_a      = 1'b0;
      load_b      = 1'b0;
      load_aluout = 1'b0;
      alu_src_a   = 3'd0;
      alu_src_b   = 3'd0;
      alu_op      = 3'd0;
      pc_src      = 2'd0;
      reg_write   = 1'b0;
      reg_dst     = 3'd0;
      mem_to_reg  = 5'd0;
      illegal     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic retire;
  assign retire = (state_d == S_FETCH) &&
                  (state_q == S_WB || state_q == S_BRANCH ||
                   state_q == S_JUMP || state_q == S_MEM_WR);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= 32'd0;
      cycle_count <= 32'd0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (retire) instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: two controllers (MEM_LAT=1 sticky trap, MEM_LAT=3 non-sticky)
// driven by independent streams and checked cycle by cycle against an instruction-level model.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic [2:0] iord;
    logic       mem_write;
    logic       load_a;
    logic       load_b;
    logic       load_aluout;
    logic [2:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [2:0] reg_dst;
    logic [4:0] mem_to_reg;
    logic       illegal;
    logic [3:0] state;
  } outs_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         cpi;
    logic       pcw;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst [2];
  logic [5:0] opc [2];
  logic [5:0] fnc [2];
  logic       zr  [2];
  outs_t      o   [2];
  logic [31:0] ic [2];
  logic [31:0] cc [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       pcw, irw, mw, la, lb, lao, rw, ill;
    logic [2:0] io, asa, asb, aop, rd;
    logic [1:0] ps;
    logic [4:0] m2r;
    logic [3:0] st;
    multicycle_ctrl #(.MEM_LAT(g == 0 ? 1 : 3), .TRAP_STICKY(g == 0)) u_dut (
      .clk(clk), .reset(rst[g]), .opcode(opc[g]), .funct(fnc[g]), .zero(zr[g]),
      .pc_write(pcw), .ir_write(irw), .iord(io), .mem_write(mw),
      .load_a(la), .load_b(lb), .load_aluout(lao),
      .alu_src_a(asa), .alu_src_b(asb), .alu_op(aop), .pc_src(ps),
      .reg_write(rw), .reg_dst(rd), .mem_to_reg(m2r), .illegal(ill), .state(st)
`ifdef MULTICYCLE_CTRL_PERF_EN
      , .instr_count(ic[g]), .cycle_count(cc[g])
`endif
    );
    assign o[g] = {pcw, irw, io, mw, la, lb, lao, asa, asb, aop, ps, rw, rd, m2r, ill, st};
  end

`ifndef MULTICYCLE_CTRL_PERF_EN
  initial begin
    ic[0] = '0; ic[1] = '0; cc[0] = '0; cc[1] = '0;
  end
`endif

  // 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 branch, 5 J, 6 illegal
  function automatic int iclass(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'h00:        return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                            fn == 6'h25 || fn == 6'h2A) ? 0 : 6;
      6'h08:        return 1;
      6'h23:        return 2;
      6'h2B:        return 3;
      6'h04, 6'h05: return 4;
      6'h02:        return 5;
      default:      return 6;
    endcase
  endfunction

  function automatic outs_t exp_outs(int st, logic [5:0] op, logic [5:0] fn, logic z);
    outs_t e = '0;
    e.state = 4'(st);
    case (st)
      0: begin e.pc_write = 1; e.ir_write = 1; e.alu_src_b = 1; e.alu_op = 1; end
      1: begin e.load_a = 1; e.load_b = 1; e.load_aluout = 1; e.alu_src_b = 3; e.alu_op = 1; end
      2: begin
        e.alu_src_a = 1; e.load_aluout = 1;
        e.alu_op = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : (fn == 6'h24) ? 3'd3 :
                   (fn == 6'h25) ? 3'd4 : 3'd5;
      end
      3, 4: begin e.alu_src_a = 1; e.alu_src_b = 2; e.alu_op = 1; e.load_aluout = 1; end
      5: e.iord = 1;
      6: begin e.iord = 1; e.mem_write = 1; end
      7: begin
        e.reg_write = 1;
        e.reg_dst = (op == 6'h00) ? 3'd0 : 3'd1;
        e.mem_to_reg = (op == 6'h23) ? 5'd1 : 5'd0;
      end
      8: begin
        e.alu_src_a = 1; e.alu_op = 2; e.pc_src = 1;
        e.pc_write = (op == 6'h04) ? z : ~z;
      end
      9: begin e.pc_src = 2; e.pc_write = 1; end
      10: e.illegal = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(string name, outs_t act, outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic do_reset(int k, int n);
    outs_t a;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst[k] = 1'b1; opc[k] = 6'h08; fnc[k] = 6'h00; zr[k] = 1'b0;
      #1;
      a = o[k];
      a.state = '0;
      chk($sformatf("d%0d_rst_outs", k), a, '0);
    end
    @(posedge clk);
    #1;
    chk_int($sformatf("d%0d_rst_state", k), o[k].state, 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk_int($sformatf("d%0d_rst_icnt", k), ic[k], 0);
    chk_int($sformatf("d%0d_rst_ccnt", k), cc[k], 0);
`endif
  endtask

  // Expected state sequence built from the instruction-class rules and memory latency.
  task automatic run_instr(int k, logic [5:0] op, logic [5:0] fn, logic z,
                           output int mcnt, output logic pcw_last);
    int q[$];
    int lat = (k == 0) ? 1 : 3;
    bit stk = (k == 0);
    int c = iclass(op, fn);
    int endst = 0;
    outs_t a;
    q = {0, 1};
    case (c)
      0: q = {q, 2, 7};
      1: q = {q, 3, 7};
      2: begin q.push_back(4); repeat (lat) q.push_back(5); q.push_back(7); end
      3: begin q.push_back(4); repeat (lat) q.push_back(6); end
      4: q.push_back(8);
      5: q.push_back(9);
      default: begin
        q.push_back(10);
        if (stk) begin repeat (10) q.push_back(10); endst = 10; end
      end
    endcase
    mcnt = 1;
    pcw_last = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rst[k] = 1'b0; opc[k] = op; fnc[k] = fn; zr[k] = z;
      #1;
      a = o[k];
      chk($sformatf("d%0d_op%h_fn%h_cyc%0d", k, op, fn, i), a, exp_outs(q[i], op, fn, z));
      if (i > 0 && a.state != 4'd0) mcnt++;
      pcw_last = a.pc_write;
    end
    @(posedge clk);
    #1;
    chk_int($sformatf("d%0d_op%h_end", k, op), o[k].state, endst);
  endtask

  task automatic rand_instr(int k, output logic [5:0] op, output logic [5:0] fn);
    int r = $urandom_range(0, 12);
    fn = 6'($urandom);
    case (r)
      0: begin op = 6'h00; fn = 6'h20; end
      1: begin op = 6'h00; fn = 6'h22; end
      2: begin op = 6'h00; fn = 6'h24; end
      3: begin op = 6'h00; fn = 6'h25; end
      4: begin op = 6'h00; fn = 6'h2A; end
      5: op = 6'h08;
      6: op = 6'h23;
      7: op = 6'h2B;
      8: op = 6'h04;
      9: op = 6'h05;
      10: op = 6'h02;
      11: begin
        op = 6'h08;
        if (k == 1) begin
          op = 6'($urandom);
          while (op == 6'h00 || iclass(op, 6'h00) != 6) op = 6'($urandom);
        end
      end
      default: begin
        op = (k == 1) ? 6'h00 : 6'h05;
        if (k == 1) while (iclass(op, fn) != 6) fn = 6'($urandom);
      end
    endcase
  endtask

  task automatic stream0();
    vec_t tv[13];
    int m;
    logic p;
    logic [5:0] op, fn;
    outs_t a;
    tv[0]  = '{6'h00, 6'h20, 1'b0, 4, 1'b0};
    tv[1]  = '{6'h00, 6'h22, 1'b1, 4, 1'b0};
    tv[2]  = '{6'h00, 6'h24, 1'b0, 4, 1'b0};
    tv[3]  = '{6'h00, 6'h25, 1'b0, 4, 1'b0};
    tv[4]  = '{6'h00, 6'h2A, 1'b0, 4, 1'b0};
    tv[5]  = '{6'h08, 6'h11, 1'b0, 4, 1'b0};
    tv[6]  = '{6'h23, 6'h00, 1'b0, 5, 1'b0};
    tv[7]  = '{6'h2B, 6'h00, 1'b0, 4, 1'b0};
    tv[8]  = '{6'h04, 6'h00, 1'b1, 3, 1'b1};
    tv[9]  = '{6'h04, 6'h00, 1'b0, 3, 1'b0};
    tv[10] = '{6'h05, 6'h00, 1'b1, 3, 1'b0};
    tv[11] = '{6'h05, 6'h00, 1'b0, 3, 1'b1};
    tv[12] = '{6'h02, 6'h00, 1'b0, 3, 1'b1};

    do_reset(0, 2);
    run_instr(0, 6'h00, 6'h22, 1'b0, m, p);
    run_instr(0, 6'h2B, 6'h00, 1'b0, m, p);
    run_instr(0, 6'h02, 6'h00, 1'b0, m, p);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk_int("perf_icnt", ic[0], 3);
    chk_int("perf_ccnt", cc[0], 11);
`endif

    for (int i = 0; i < 13; i++) begin
      run_instr(0, tv[i].op, tv[i].fn, tv[i].z, m, p);
      chk_int($sformatf("tv%0d_cpi", i), m, tv[i].cpi);
      chk_int($sformatf("tv%0d_pcw", i), p, tv[i].pcw);
    end

    for (int i = 0; i < 40; i++) begin
      rand_instr(0, op, fn);
      run_instr(0, op, fn, 1'($urandom), m, p);
    end

    // Sticky trap: stays in TRAP until reset, then normal fetch resumes.
    run_instr(0, 6'h3F, 6'h00, 1'b0, m, p);
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    a = o[0];
    chk_int("trap_rst_illegal", a.illegal, 0);
    @(posedge clk);
    #1;
    chk_int("trap_rst_state", o[0].state, 0);
    run_instr(0, 6'h00, 6'h20, 1'b0, m, p);
  endtask

  task automatic stream1();
    int m;
    logic p;
    logic [5:0] op, fn;
    outs_t a;
    do_reset(1, 2);
    run_instr(1, 6'h23, 6'h00, 1'b0, m, p);
    chk_int("lw_lat3_cpi", m, 7);
    run_instr(1, 6'h2B, 6'h00, 1'b0, m, p);
    chk_int("sw_lat3_cpi", m, 6);
    run_instr(1, 6'h3F, 6'h00, 1'b0, m, p);
    chk_int("trap_pulse_cpi", m, 3);
    run_instr(1, 6'h00, 6'h00, 1'b0, m, p);
    for (int i = 0; i < 40; i++) begin
      rand_instr(1, op, fn);
      run_instr(1, op, fn, 1'($urandom), m, p);
    end

    // Reset lands in the middle of a store.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst[1] = 1'b0; opc[1] = 6'h2B; fnc[1] = 6'h00; zr[1] = 1'b0;
      #1;
    end
    chk("sw_pre_rst", o[1], exp_outs(6, 6'h2B, 6'h00, 1'b0));
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    a = o[1];
    chk_int("sw_rst_state_held", a.state, 6);
    chk_int("sw_rst_mem_write", a.mem_write, 0);
    a.state = '0;
    chk("sw_rst_outs", a, '0);
    @(posedge clk);
    #1;
    chk_int("sw_rst_state", o[1].state, 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk_int("sw_rst_icnt", ic[1], 0);
    chk_int("sw_rst_ccnt", cc[1], 0);
`endif
    run_instr(1, 6'h08, 6'h00, 1'b0, m, p);
  endtask

  initial begin
    rst[0] = 1'b1; rst[1] = 1'b1;
    opc[0] = 6'h08; opc[1] = 6'h08;
    fnc[0] = 6'h00; fnc[1] = 6'h00;
    zr[0] = 1'b0; zr[1] = 1'b0;
    fork
      stream0();
      stream1();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
